// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Fetches IW-bit instructions from a word-addressed instruction memory and
//   presents them, with the opcode field split out, to the control decoder
//   and register-file read stage. Owns the fetch PC, a 2-entry prefetch
//   buffer, branch redirect/flush and HALT detection.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   imem_req/imem_addr  read request; the address is held until imem_ack
//   imem_ack/imem_rdata read completion and data
//   instr_valid/ready   valid/ready handshake for the head instruction
//   instr/opcode        head instruction and its top 4 bits
//   instr_pc            address of the head instruction
//   branch_taken/target one-cycle redirect pulse and new fetch address
//   halted              sticky flag: a HALT_OP instruction was consumed
//
// Optional build macro IFU_PERF_CNT_EN adds saturating 32-bit counters:
//   fetch_cnt  instructions pushed into the buffer
//   stall_cnt  cycles with imem_req=1 and imem_ack=0
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int         AW      = 8,
  parameter int         IW      = 16,
  parameter logic [3:0] HALT_OP = 4'b1111
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [IW-1:0] instr,
  output logic [3:0]    opcode,
  output logic [AW-1:0] instr_pc,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_target,
  output logic          halted
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]   fetch_cnt,
  output logic [31:0]   stall_cnt
`endif
);

  localparam int DEPTH = 2;
  localparam int EW    = AW + IW;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DROP} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] fetch_pc_reg;
  logic [AW-1:0] addr_reg;
  logic [1:0]    count_reg;
  logic          stop_fetch_reg;
  logic          halted_reg;
  logic          start_req;
  logic          push;
  logic          pop;
  logic [1:0]    wr_idx;
  logic [EW-1:0] head;

  // Branch suppresses both buffer operations: the flush wins.
  assign instr_valid = (count_reg != 2'd0);
  assign pop         = instr_valid & instr_ready & ~branch_taken;
  assign push        = (state_reg == ST_REQ) & imem_ack & ~branch_taken;
  // Slot a new entry lands in, after accounting for a same-cycle pop.
  // Also serves as the occupancy seen by the IDLE request decision.
  assign wr_idx      = count_reg - {1'b0, pop};

  // ---------------- FSM: next state and outputs ----------------
  always_comb begin
    state_next = state_reg;
    start_req  = 1'b0;
    imem_req   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if ((wr_idx < 2'd2) && !stop_fetch_reg && !branch_taken) begin
          state_next = ST_REQ;
          start_req  = 1'b1;
        end
      end
      ST_REQ: begin
        imem_req = 1'b1;
        if (imem_ack)          state_next = ST_IDLE;
        else if (branch_taken) state_next = ST_DROP;
      end
      ST_DROP: begin
        // A request is never withdrawn; wait out the ack and discard it.
        imem_req = 1'b1;
        if (imem_ack) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------- FSM, PC and control state ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      fetch_pc_reg   <= '0;
      addr_reg       <= '0;
      count_reg      <= 2'd0;
      stop_fetch_reg <= 1'b0;
      halted_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      // Request address is latched separately so it stays stable in DROP
      // even though fetch_pc has already moved to the branch target.
      if (start_req) addr_reg <= fetch_pc_reg;
      if (branch_taken) begin
        fetch_pc_reg   <= branch_target;
        count_reg      <= 2'd0;
        stop_fetch_reg <= 1'b0;
      end else begin
        count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
        if (push) begin
          fetch_pc_reg <= fetch_pc_reg + 1'b1;
          if (imem_rdata[IW-1 -: 4] == HALT_OP) stop_fetch_reg <= 1'b1;
        end
        if (pop && (head[IW-1 -: 4] == HALT_OP)) halted_reg <= 1'b1;
      end
    end
  end

  // ---------------- Prefetch buffer (shift FIFO, slot 0 = head) ----------------
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_slot
      localparam logic [1:0] SLOT = 2'(gi);
      logic [EW-1:0] entry_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          entry_reg <= '0;
        end else if (!branch_taken) begin
          if (push && (wr_idx == SLOT)) begin
            entry_reg <= {addr_reg, imem_rdata};
          end else if (pop) begin
            if (gi < DEPTH - 1) entry_reg <= gen_slot[(gi < DEPTH - 1) ? gi + 1 : gi].entry_reg;
          end
        end
      end
    end
  endgenerate

  assign head      = gen_slot[0].entry_reg;
  assign instr     = head[IW-1:0];
  assign opcode    = head[IW-1 -: 4];
  assign instr_pc  = head[EW-1:IW];
  assign imem_addr = addr_reg;
  assign halted    = halted_reg;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_reg;
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_reg <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (push && (fetch_cnt_reg != 32'hFFFF_FFFF))
        fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
      if (imem_req && !imem_ack && (stall_cnt_reg != 32'hFFFF_FFFF))
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_reg;
  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Directed bench for instr_fetch_unit. A memory responder with programmable
//   ack delay runs inside the cycle() task; every accepted read pushes the
//   expected {addr, data} onto a scoreboard queue, every instruction accepted
//   downstream pops and compares it. Branches flush the scoreboard.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic [7:0]  instr_pc;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        halted;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(.AW(8), .IW(16), .HALT_OP(4'b1111)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .opcode       (opcode),
    .instr_pc     (instr_pc),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .halted       (halted)
`ifdef IFU_PERF_CNT_EN
    ,
    .fetch_cnt    (fetch_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  int          checks = 0;
  int          failures = 0;
  int          pushes = 0;
  int          pops = 0;
  int          wait_cnt = 0;
  int          ack_delay = 0;
  int          base;
  bit          drop_flag = 1'b0;
  bit          saw6 = 1'b0;
  bit          halt_popped = 1'b0;
  bit          force_ack = 1'b0;
  logic [7:0]  last_pop_pc = 8'h00;
  logic [7:0]  a0;
  logic [15:0] mem [256];
  logic [23:0] exp_q [$];
  logic [23:0] pop_log [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: respond as memory, update scoreboard for what the DUT will do
  // at the coming edge, then advance to 1 time unit after that edge.
  task automatic cycle();
    logic [23:0] e;
    imem_ack = 1'b0;
    if (reset) begin
      wait_cnt  = 0;
      drop_flag = 1'b0;
      exp_q.delete();
    end else begin
      if (force_ack) begin
        imem_ack   = 1'b1;
        imem_rdata = 16'hF000;
        force_ack  = 1'b0;
      end else if (imem_req) begin
        if (imem_addr == 8'd6) saw6 = 1'b1;
        if (wait_cnt < ack_delay) begin
          wait_cnt++;
        end else begin
          imem_ack   = 1'b1;
          imem_rdata = mem[imem_addr];
          wait_cnt   = 0;
        end
      end
      // consumer side
      if (branch_taken) begin
        exp_q.delete();
      end else if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", instr_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("pop_instr", instr, e[15:0]);
          check("pop_pc", instr_pc, e[23:16]);
          check("pop_opcode", opcode, e[15:12]);
          if (e[15:12] == 4'hF) halt_popped = 1'b1;
        end
        pops++;
        last_pop_pc = instr_pc;
        pop_log.push_back({instr_pc, instr});
        $display("t=%0t pop pc=%02h instr=%04h", $time, instr_pc, instr);
      end
      // producer side
      if (imem_req && imem_ack) begin
        if (!branch_taken && !drop_flag) begin
          exp_q.push_back({imem_addr, imem_rdata});
          pushes++;
        end
        drop_flag = 1'b0;
      end else if (imem_req && branch_taken) begin
        drop_flag = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i);
    reset         = 1'b1;
    imem_ack      = 1'b0;
    imem_rdata    = 16'h0000;
    instr_ready   = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 8'h00;
    repeat (3) @(posedge clk);
    #1;

    // ---- reset state ----
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_opcode", opcode, 0);
    check("rst_pc", instr_pc, 0);
    check("rst_halted", halted, 0);

    // ---- 1: streaming with immediate acks ----
    reset       = 1'b0;
    instr_ready = 1'b1;
    cycle();
    check("lat_req", imem_req, 1);
    check("lat_addr", imem_addr, 0);
    cycle();
    check("first_valid", instr_valid, 1);
    check("first_instr", instr, 16'h0000);
    check("first_pc", instr_pc, 8'h00);
    check("first_opcode", opcode, 0);
    for (int i = 0; i < 20 && pops < 3; i++) cycle();
    check("t1_seq0", pop_log[0], 24'h00_0000);
    check("t1_seq1", pop_log[1], 24'h01_0001);
    check("t1_seq2", pop_log[2], 24'h02_0002);

    // ---- 2: backpressure fills the buffer, then resumes ----
    instr_ready   = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 8'h20;
    cycle();
    branch_taken  = 1'b0;
    base = pushes;
    for (int i = 0; i < 10; i++) begin
      if (i >= 7) check("t2_idle_req", imem_req, 0);
      cycle();
    end
    check("t2_completed", pushes - base, 2);
    check("t2_valid", instr_valid, 1);
    check("t2_head_pc", instr_pc, 8'h20);
    instr_ready = 1'b1;
    repeat (8) cycle();

    // ---- 3: branch during a delayed ack ----
    ack_delay = 3;
    for (int i = 0; i < 10 && !imem_req; i++) cycle();
    check("t3_req", imem_req, 1);
    a0            = imem_addr;
    branch_taken  = 1'b1;
    branch_target = 8'h40;
    cycle();
    branch_taken  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t3_hold_req", imem_req, 1);
      check("t3_hold_addr", imem_addr, a0);
      check("t3_no_valid", instr_valid, 0);
      cycle();
    end
    check("t3_after_req", imem_req, 0);
    check("t3_after_valid", instr_valid, 0);
    cycle();
    check("t3_redir_req", imem_req, 1);
    check("t3_redir_addr", imem_addr, 8'h40);
    ack_delay = 0;
    repeat (6) cycle();

    // ---- 4: branch coinciding with ack ----
    for (int i = 0; i < 10 && !imem_req; i++) cycle();
    check("t4_req", imem_req, 1);
    branch_taken  = 1'b1;
    branch_target = 8'h10;
    cycle();
    branch_taken  = 1'b0;
    base = pops;
    for (int i = 0; i < 20 && pops == base; i++) cycle();
    check("t4_first_pc", last_pop_pc, 8'h10);

    // ---- 5: HALT at address 5 ----
    mem[5]        = 16'hF000;
    branch_taken  = 1'b1;
    branch_target = 8'h03;
    cycle();
    branch_taken  = 1'b0;
    saw6          = 1'b0;
    halt_popped   = 1'b0;
    check("t5_pre_halted", halted, 0);
    for (int i = 0; i < 30 && !halt_popped; i++) cycle();
    check("t5_halt_popped", halt_popped, 1);
    check("t5_halted", halted, 1);
    repeat (10) cycle();
    check("t5_no_req6", saw6, 0);
    check("t5_req_idle", imem_req, 0);
    check("t5_still_halted", halted, 1);
    check("t5_empty", instr_valid, 0);

    // ---- 6: PC wrap, branch while halted ----
    branch_taken  = 1'b1;
    branch_target = 8'hFF;
    cycle();
    branch_taken  = 1'b0;
    for (int i = 0; i < 20 && !(imem_req && imem_addr == 8'hFF); i++) cycle();
    check("t6_addr_ff", imem_addr, 8'hFF);
    cycle();
    cycle();
    check("t6_wrap_req", imem_req, 1);
    check("t6_wrap_addr", imem_addr, 8'h00);
    check("t6_halted_kept", halted, 1);

    // ---- mid-operation reset, late ack, counters ----
    ack_delay = 3;
    cycle();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    check("mr_halted", halted, 0);
    check("mr_req", imem_req, 0);
    check("mr_valid", instr_valid, 0);
    force_ack = 1'b1;
    ack_delay = 2;
    base = pushes;
    cycle();
    check("mr_late_req", imem_req, 1);
    check("mr_late_addr", imem_addr, 8'h00);
    check("mr_late_valid", instr_valid, 0);
    for (int i = 0; i < 40 && (pushes - base) < 4; i++) cycle();
    check("perf_pushes", pushes - base, 4);
`ifdef IFU_PERF_CNT_EN
    check("perf_fetch_cnt", fetch_cnt, 4);
    check("perf_stall_cnt", stall_cnt, 8);
`endif
    repeat (4) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
